// File: rtl/hififo_rc_parse.sv
// hififo_rc_parse: RX TLP parser that turns CplD payloads into tagged quadwords and 3-DW MWr into PIO strobes.
// Optional dropped-TLP counter is built when HIFIFO_RC_ERRCNT_EN is defined.
module hififo_rc_parse (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] rx_tdata,
  input  logic [7:0]  rx_tkeep,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  output logic        rx_tready,
  output logic [63:0] rx_data,
  output logic        rc_valid,
  output logic [7:0]  rc_tag,
  output logic [5:0]  rc_index,
  output logic        pio_wvalid,
  output logic [12:0] pio_addr,
  output logic [15:0] err_count
);
  localparam int unsigned FT_W = 8;
  localparam logic [FT_W-1:0] FT_CPLD  = 8'b010_01010;
  localparam logic [FT_W-1:0] FT_MWR32 = 8'b010_00000;

  typedef enum logic [1:0] {HDR0, HDR1, DATA, DROP} state_t;
  state_t state, state_nxt;

  logic [FT_W-1:0] fmt_type;
  logic [9:0]      length;
  logic [2:0]      status;
  logic [11:0]     byte_count;
  logic [31:0]     hold;
  logic [7:0]      tag;
  logic [5:0]      index;
  logic [12:0]     addr;
  logic            mode_rc;
  logic            mode_pio;
  logic            pio_done;

  logic            is_cpld_c;
  logic            is_mwr_c;
  logic            emit_rc_c;
  logic            emit_pio_c;
  logic            drop_c;
  logic [11:0]     bc_off_c;

  assign rx_tready = 1'b1;

  // Decode of the header latched from beat 0
  assign is_cpld_c = (fmt_type == FT_CPLD) && (status == 3'b000) &&
                     !length[0] && (length != 10'd0);
  assign is_mwr_c  = (fmt_type == FT_MWR32) && (length == 10'd2);
  assign bc_off_c  = 12'h200 - byte_count;

  always_ff @(posedge clock) begin
    if (reset) state <= HDR0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    emit_rc_c  = 1'b0;
    emit_pio_c = 1'b0;
    drop_c     = 1'b0;
    if (rx_tvalid) begin
      case (state)
        HDR0: begin
          if (rx_tlast) drop_c = 1'b1;
          else          state_nxt = HDR1;
        end
        HDR1: begin
          drop_c = !(is_cpld_c || is_mwr_c);
          if (rx_tlast)    state_nxt = HDR0;
          else if (drop_c) state_nxt = DROP;
          else             state_nxt = DATA;
        end
        DATA: begin
          emit_rc_c  = mode_rc;
          emit_pio_c = mode_pio && !pio_done;
          if (rx_tlast) state_nxt = HDR0;
        end
        DROP: begin
          if (rx_tlast) state_nxt = HDR0;
        end
        default: state_nxt = HDR0;
      endcase
    end
  end

  // Header capture, realignment hold register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      fmt_type   <= '0;
      length     <= '0;
      status     <= '0;
      byte_count <= '0;
      hold       <= '0;
      tag        <= '0;
      index      <= '0;
      addr       <= '0;
      mode_rc    <= 1'b0;
      mode_pio   <= 1'b0;
      pio_done   <= 1'b0;
      rx_data    <= '0;
      rc_valid   <= 1'b0;
      rc_tag     <= '0;
      rc_index   <= '0;
      pio_wvalid <= 1'b0;
      pio_addr   <= '0;
    end else begin
      rc_valid   <= emit_rc_c;
      pio_wvalid <= emit_pio_c;
      if (rx_tvalid && state == HDR0) begin
        fmt_type   <= rx_tdata[31:24];
        length     <= rx_tdata[9:0];
        status     <= rx_tdata[47:45];
        byte_count <= rx_tdata[43:32];
      end
      if (rx_tvalid && state == HDR1) begin
        hold     <= rx_tdata[63:32];
        mode_rc  <= is_cpld_c;
        mode_pio <= is_mwr_c;
        pio_done <= 1'b0;
        if (is_cpld_c) begin
          tag   <= rx_tdata[15:8];
          index <= bc_off_c[8:3];
        end
        if (is_mwr_c) addr <= rx_tdata[15:3];
      end
      if (rx_tvalid && state == DATA) hold <= rx_tdata[63:32];
      if (emit_rc_c || emit_pio_c) rx_data <= {rx_tdata[31:0], hold};
      if (emit_rc_c) begin
        rc_tag   <= tag;
        rc_index <= index;
        index    <= index + 6'd1;
      end
      if (emit_pio_c) begin
        pio_addr <= addr;
        pio_done <= 1'b1;
      end
    end
  end

`ifdef HIFIFO_RC_ERRCNT_EN
  logic unused_bits;
  assign unused_bits = ^{rx_tkeep, rx_tdata[23:10], rx_tdata[44], bc_off_c[11:9], bc_off_c[2:0]};

  // Saturating count of dropped TLPs
  always_ff @(posedge clock) begin
    if (reset)                               err_count <= '0;
    else if (drop_c && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{rx_tkeep, rx_tdata[23:10], rx_tdata[44], bc_off_c[11:9], bc_off_c[2:0], drop_c};
  assign err_count   = 16'd0;
`endif

endmodule
